// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding,
// default bus widths and the watchdog counter width helper.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  // Counter must hold TIMEOUT_CYCLES and is never narrower than 8 bits.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/wb_cmd_watchdog.sv
// BUS-phase timeout counter for wb_cmd_master. Only compiled when
// WB_MASTER_TIMEOUT_EN is defined; the default build contains no counter.
`ifdef WB_MASTER_TIMEOUT_EN
module wb_cmd_watchdog
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count stalled BUS cycles; saturate so a stuck enable cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires on the stalled cycle that would bring the count to the limit, so
  // the master leaves BUS after exactly TIMEOUT_CYCLES cycles of strobe.
  assign expired_o = en_i && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/wb_cmd_master.sv
// Wishbone classic (B4, single beat) initiator driven by a valid/ready
// command port, returning read data / error on a valid/ready response port.
// Optional BUS timeout: define WB_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned AW             = DEF_AW,
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output logic            busy_o
);

  localparam int unsigned SW = DW / 8;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic            timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
  // Watchdog runs only while strobing and pauses on the completing cycle so
  // a late ack/err always beats the timeout.
  wb_cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clr_i     (state_q != ST_BUS),
    .en_i      ((state_q == ST_BUS) && !wbm_ack_i && !wbm_err_i),
    .expired_o (timeout_hit)
  );
`else
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] unused_timeout;
  assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and datapath: latch command, hold bus until completion, hold response until taken.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_BUS;
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i || wbm_err_i || timeout_hit) begin
          state_d   = ST_RESP;
          we_d      = 1'b0;
          sel_d     = '0;
          adr_d     = '0;
          dat_d     = '0;
          rsp_err_d = wbm_err_i || timeout_hit;
          rsp_dat_d = (wbm_ack_i && !wbm_err_i && !we_q) ? wbm_dat_i : '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d   = ST_IDLE;
          rsp_dat_d = '0;
          rsp_err_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset abandons any cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Handshake and strobe outputs decode straight from the state register.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign wbm_cyc_o   = (state_q == ST_BUS);
  assign wbm_stb_o   = (state_q == ST_BUS);
  assign busy_o      = (state_q != ST_IDLE);
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: table of single transactions plus
// hand-written sequences for stray ack, reset in BUS and the stalled slave.
module tb_wb_cmd_master;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, sdat;
  logic        ack, err, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(sdat),
    .wbm_ack_i(ack), .wbm_err_i(err), .busy_o(busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          delay;
    logic        ack;
    logic        err;
    logic [31:0] sdat;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_dat   = v.wdat;
    cmd_sel   = v.sel;
  endtask

  // One full transaction from IDLE; optionally holds the response for
  // 'hold' cycles while the next command is already being offered.
  task automatic do_txn(input vec_t v, input int hold, input logic pend, input vec_t nxt);
    chk("idle_ready", {31'b0, cmd_ready}, 32'd1);
    drive_cmd(v);
    tick();
    cmd_valid = 1'b0;
    chk("bus_cyc", {31'b0, cyc}, 32'd1);
    chk("bus_stb", {31'b0, stb}, 32'd1);
    chk("bus_ready_low", {31'b0, cmd_ready}, 32'd0);
    chk("bus_we", {31'b0, we}, {31'b0, v.we});
    chk("bus_adr", adr, v.adr);
    chk("bus_dat", wdat, v.wdat);
    chk("bus_sel", {28'b0, sel}, {28'b0, v.sel});
    for (int d = 0; d < v.delay; d++) begin
      tick();
      chk("wait_cyc", {31'b0, cyc}, 32'd1);
      chk("wait_adr", adr, v.adr);
      chk("wait_dat", wdat, v.wdat);
      chk("wait_sel", {28'b0, sel}, {28'b0, v.sel});
    end
    ack  = v.ack;
    err  = v.err;
    sdat = v.sdat;
    tick();
    ack  = 1'b0;
    err  = 1'b0;
    sdat = 32'h0;
    chk("done_cyc", {31'b0, cyc}, 32'd0);
    chk("done_stb", {31'b0, stb}, 32'd0);
    chk("done_adr_clr", adr, 32'h0);
    chk("done_sel_clr", {28'b0, sel}, 32'h0);
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_dat", rsp_dat, v.exp_dat);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
    if (pend) drive_cmd(nxt);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_dat", rsp_dat, v.exp_dat);
      chk("hold_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
      chk("hold_ready_low", {31'b0, cmd_ready}, 32'd0);
      chk("hold_no_cyc", {31'b0, cyc}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_valid_low", {31'b0, rsp_valid}, 32'd0);
    chk("hs_ready_high", {31'b0, cmd_ready}, 32'd1);
    chk("hs_busy_low", {31'b0, busy}, 32'd0);
    chk("hs_no_cyc", {31'b0, cyc}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'h3, 0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h3000_0010, 32'h0000_00C3, 4'h1, 0, 1'b0, 1'b1, 32'h0,         32'h0, 1'b1};
    vecs[4] = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 3, 1'b0, 1'b1, 32'h0000_55AA, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 32'h3000_0020, 32'h0,         4'hC, 0, 1'b1, 1'b0, 32'hFFFF_0001, 32'hFFFF_0001, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; err = 1'b0; sdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_cyc_stb_we", {29'b0, cyc, stb, we}, 32'd0);
    chk("rst_sel", {28'b0, sel}, 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_dat", wdat, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Table: vector 1 holds its response 5 cycles while vector 2 waits.
    for (int i = 0; i < NV; i++) begin
      do_txn(vecs[i], (i == 1) ? 5 : 0, (i == 1), vecs[(i + 1) % NV]);
    end

    // Stray ack/err while idle must not start anything.
    ack = 1'b1; err = 1'b1; sdat = 32'hBAD0_BAD0;
    tick();
    tick();
    ack = 1'b0; err = 1'b0; sdat = 32'h0;
    chk("stray_busy", {31'b0, busy}, 32'd0);
    chk("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("stray_cyc", {31'b0, cyc}, 32'd0);
    chk("stray_ready", {31'b0, cmd_ready}, 32'd1);

    // Reset pulse during BUS abandons the cycle with no response.
    drive_cmd(vecs[0]);
    tick();
    cmd_valid = 1'b0;
    chk("rstbus_cyc_before", {31'b0, cyc}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstbus_cyc", {31'b0, cyc}, 32'd0);
    chk("rstbus_stb", {31'b0, stb}, 32'd0);
    chk("rstbus_busy", {31'b0, busy}, 32'd0);
    chk("rstbus_adr", adr, 32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rstbus_no_rsp", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    do_txn(vecs[1], 0, 1'b0, vecs[1]);

    // Slave that never answers.
    drive_cmd(vecs[1]);
    tick();
    cmd_valid = 1'b0;
    chk("to_cyc_start", {31'b0, cyc}, 32'd1);
`ifdef WB_MASTER_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("to_cyc_held", {31'b0, cyc}, 32'd1);
    end
    tick();
    chk("to_cyc_drop", {31'b0, cyc}, 32'd0);
    chk("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'b0, rsp_err}, 32'd1);
    chk("to_rsp_dat", rsp_dat, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_hs_ready", {31'b0, cmd_ready}, 32'd1);
`else
    repeat (1000) tick();
    chk("noto_cyc_high", {31'b0, cyc}, 32'd1);
    chk("noto_no_rsp", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("noto_cleared", {31'b0, cyc}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
